field_order_merger: RTL and testbench
=====================================

Name: field_order_merger

Overview:
- Scheduler that shares the single byte-wide output FIFO between the varint encoder output stream and the raw-data byte stream.
- Each stream presents show-ahead head bytes tagged with a protobuf field index.
- The block emits whole fields in ascending field-index order, never interleaving bytes of two fields.
- It detects end of message and reports the message byte count, so the AXI read side knows how many bytes are valid.

Parameters:
- IDX_W, 10, width of field index tags
- DATA_W, 8, width of a data byte
- CNT_W, 16, width of message byte counter

Ports:
- clock_clk  in  1  clock
- reset_reset  in  1  asynchronous active-high reset
- clr  in  1  synchronous abort/clear of the current message
- v_valid  in  1  varint stream head valid (out FIFO not empty)
- v_data  in  DATA_W  varint head byte
- v_index  in  IDX_W  varint head field index
- v_done  in  1  varint producer has written all fields of this message (level)
- v_pop  out  1  pop varint head (combinational pulse)
- r_valid  in  1  raw stream head valid
- r_data  in  DATA_W  raw head byte
- r_index  in  IDX_W  raw head field index
- r_done  in  1  raw producer finished message (level)
- r_pop  out  1  pop raw head
- out_full  in  1  output FIFO full
- out_push  out  1  output FIFO write strobe
- out_data  out  DATA_W  output FIFO write data
- msg_complete  out  1  one-cycle pulse, message fully forwarded
- done_ack  out  1  one-cycle pulse with msg_complete; producers drop *_done
- msg_bytes  out  CNT_W  bytes forwarded in last/current message
- err_order  out  1  sticky: a source presented an index below the last emitted index

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; cur_src=varint, cur_idx=0, last_idx=0.
- clr has priority over all other logic: next state IDLE, msg_bytes=0, err_order=0, no pop that cycle.
- Pops, out_push and out_data are combinational in the pop cycle, so latency is zero:
  - out_push = v_pop | r_pop; at most one pop per cycle.
  - out_data = head byte of the popped source; 0 when out_push=0.
- No pop while out_full=1.
- Eligibility:
  - elig_v = v_valid & (r_valid ? v_index <= r_index : r_done).
  - elig_r = r_valid & (v_valid ? r_index < v_index : v_done).
  - Equal indices on both sources: varint wins.
- State IDLE:
  - Any of v_valid, r_valid, v_done or r_done set -> SELECT.
- State SELECT:
  - If elig_v or elig_r: latch cur_src and cur_idx = its head index -> DRAIN. No pop in the SELECT cycle.
  - Else if v_done & r_done & !v_valid & !r_valid -> COMPLETE.
  - Else stay.
- State DRAIN (selected source S):
  - S valid, index==cur_idx, !out_full: pop. msg_bytes increments (saturates at all-ones). last_idx=cur_idx. Stay.
  - S valid, index != cur_idx: field ended -> SELECT.
  - S empty and S_done: -> SELECT.
  - S empty and !S_done: stay; the field may continue.
  - out_full: stay, no pop.
- State COMPLETE:
  - msg_complete=1 and done_ack=1 for exactly one cycle -> IDLE.
  - msg_bytes holds its value until the first pop of the next message, which reloads it to 1.
- Ordering error: in SELECT or DRAIN, any valid head index < last_idx while msg_bytes != 0 sets err_order. Forwarding continues unchanged.
- Empty message (both done, no data): SELECT -> COMPLETE; msg_bytes=0.
- Reset asserted mid-DRAIN: immediate IDLE; a partially forwarded field is not rolled back.

Test Plan:
- Varint fields 1 (bytes 0x96,0x01) and 3 (0x05); raw field 2 (0x41,0x42); both done -> out_data sequence 96,01,41,42,05; msg_bytes=5; single msg_complete pulse.
- Varint head idx 4, raw empty with r_done=0 -> no pop until raw presents idx 2 or r_done=1; raw idx 2 is forwarded first.
- out_full held high for 3 cycles during a 4-byte raw field -> no push while full; bytes forwarded in order afterward; msg_bytes=4.
- Both done with no data -> msg_complete one cycle after leaving IDLE; msg_bytes=0; no push.
- Varint emits idx 5, then presents idx 2 -> err_order=1 and sticky; clr pulse -> err_order=0, msg_bytes=0, state IDLE.
- reset_reset asserted mid-field, asynchronous to the clock -> outputs 0 in the same cycle; after release, the next message counts from 1.

Source files
------------

// File: rtl/field_order_merger.sv
// Merges the varint and raw-data byte streams into one output FIFO, emitting whole
// protobuf fields in ascending index order and reporting the per-message byte count.
module field_order_merger #(
  parameter int unsigned IDX_W  = 10,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock_clk,
  input  logic              reset_reset,
  input  logic              clr,
  input  logic              v_valid,
  input  logic [DATA_W-1:0] v_data,
  input  logic [IDX_W-1:0]  v_index,
  input  logic              v_done,
  output logic              v_pop,
  input  logic              r_valid,
  input  logic [DATA_W-1:0] r_data,
  input  logic [IDX_W-1:0]  r_index,
  input  logic              r_done,
  output logic              r_pop,
  input  logic              out_full,
  output logic              out_push,
  output logic [DATA_W-1:0] out_data,
  output logic              msg_complete,
  output logic              done_ack,
  output logic [CNT_W-1:0]  msg_bytes,
  output logic              err_order
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SELECT, DRAIN, COMPLETE} state_t;
  typedef enum logic {SRC_V = 1'b0, SRC_R = 1'b1} src_t;

  state_t            state, state_n;
  src_t              cur_src, cur_src_n;
  logic [IDX_W-1:0]  cur_idx, cur_idx_n;
  logic [IDX_W-1:0]  last_idx;
  logic              reload;
  logic              elig_v, elig_r;
  logic              s_valid, s_done;
  logic [IDX_W-1:0]  s_index;
  logic              pop;
  logic              order_viol;

  // Lowest head index wins; a lone head may only go once the other side is done.
  assign elig_v = v_valid & (r_valid ? (v_index <= r_index) : r_done);
  assign elig_r = r_valid & (v_valid ? (r_index <  v_index) : v_done);

  assign s_valid = (cur_src == SRC_V) ? v_valid : r_valid;
  assign s_done  = (cur_src == SRC_V) ? v_done  : r_done;
  assign s_index = (cur_src == SRC_V) ? v_index : r_index;

  assign pop      = v_pop | r_pop;
  assign out_push = pop;
  assign out_data = v_pop ? v_data : (r_pop ? r_data : '0);

  // Only heads seen after a byte of the current message has gone out are checked.
  assign order_viol = ((state == SELECT) || (state == DRAIN)) &&
                      (msg_bytes != '0) && !reload &&
                      ((v_valid && (v_index < last_idx)) ||
                       (r_valid && (r_index < last_idx)));

  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) state <= IDLE;
    else             state <= state_n;
  end

  always_comb begin
    state_n   = state;
    cur_src_n = cur_src;
    cur_idx_n = cur_idx;
    v_pop     = 1'b0;
    r_pop     = 1'b0;
    case (state)
      IDLE: begin
        if (v_valid || r_valid || v_done || r_done) state_n = SELECT;
      end
      SELECT: begin
        if (elig_v) begin
          cur_src_n = SRC_V;
          cur_idx_n = v_index;
          state_n   = DRAIN;
        end else if (elig_r) begin
          cur_src_n = SRC_R;
          cur_idx_n = r_index;
          state_n   = DRAIN;
        end else if (v_done && r_done && !v_valid && !r_valid) begin
          state_n = COMPLETE;
        end
      end
      DRAIN: begin
        if (s_valid) begin
          if (s_index != cur_idx) begin
            state_n = SELECT;
          end else if (!out_full) begin
            v_pop = (cur_src == SRC_V);
            r_pop = (cur_src == SRC_R);
          end
        end else if (s_done) begin
          state_n = SELECT;
        end
      end
      COMPLETE: state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    if (clr) begin
      state_n   = IDLE;
      cur_src_n = cur_src;
      cur_idx_n = cur_idx;
      v_pop     = 1'b0;
      r_pop     = 1'b0;
    end
  end

  // Field selection, byte counter, completion pulses and sticky order error.
  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      cur_src      <= SRC_V;
      cur_idx      <= '0;
      last_idx     <= '0;
      reload       <= 1'b0;
      msg_bytes    <= '0;
      err_order    <= 1'b0;
      msg_complete <= 1'b0;
      done_ack     <= 1'b0;
    end else if (clr) begin
      reload       <= 1'b0;
      msg_bytes    <= '0;
      err_order    <= 1'b0;
      msg_complete <= 1'b0;
      done_ack     <= 1'b0;
    end else begin
      cur_src      <= cur_src_n;
      cur_idx      <= cur_idx_n;
      msg_complete <= (state_n == COMPLETE);
      done_ack     <= (state_n == COMPLETE);
      if (order_viol) err_order <= 1'b1;
      if (pop) begin
        last_idx  <= cur_idx;
        reload    <= 1'b0;
        if (reload)                    msg_bytes <= CNT_W'(1);
        else if (msg_bytes != CNT_MAX) msg_bytes <= msg_bytes + CNT_W'(1);
      end else if (state == COMPLETE) begin
        reload <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_field_order_merger.sv
// Randomized self-checking bench for field_order_merger: producers feed show-ahead
// queues and a sorted-merge scoreboard predicts the output byte order and counts.
module tb_field_order_merger;

  localparam int unsigned IDX_W  = 10;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;

  logic              clock_clk = 1'b0;
  logic              reset_reset = 1'b0;
  logic              clr = 1'b0;
  logic              v_valid = 1'b0;
  logic [DATA_W-1:0] v_data = '0;
  logic [IDX_W-1:0]  v_index = '0;
  logic              v_done = 1'b0;
  logic              v_pop;
  logic              r_valid = 1'b0;
  logic [DATA_W-1:0] r_data = '0;
  logic [IDX_W-1:0]  r_index = '0;
  logic              r_done = 1'b0;
  logic              r_pop;
  logic              out_full = 1'b0;
  logic              out_push;
  logic [DATA_W-1:0] out_data;
  logic              msg_complete;
  logic              done_ack;
  logic [CNT_W-1:0]  msg_bytes;
  logic              err_order;

  typedef struct packed {
    logic              raw;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] dat;
  } item_t;

  item_t v_pend[$], r_pend[$], v_fifo[$], r_fifo[$], exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cnt_model = 0;
  bit    new_msg = 1'b0;

  always #5 clock_clk = ~clock_clk;

  field_order_merger #(.IDX_W(IDX_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock_clk(clock_clk), .reset_reset(reset_reset), .clr(clr),
    .v_valid(v_valid), .v_data(v_data), .v_index(v_index), .v_done(v_done), .v_pop(v_pop),
    .r_valid(r_valid), .r_data(r_data), .r_index(r_index), .r_done(r_done), .r_pop(r_pop),
    .out_full(out_full), .out_push(out_push), .out_data(out_data),
    .msg_complete(msg_complete), .done_ack(done_ack), .msg_bytes(msg_bytes),
    .err_order(err_order)
  );

  function automatic void push_item(input bit raw, input int idx, input int dat);
    item_t it;
    it.raw = raw;
    it.idx = IDX_W'(idx);
    it.dat = DATA_W'(dat);
    if (raw) r_pend.push_back(it);
    else     v_pend.push_back(it);
  endfunction

  function automatic void add_field(input bit raw, input int idx, input int n);
    for (int i = 0; i < n; i++) push_item(raw, idx, int'($urandom_range(0, 255)));
  endfunction

  // Expected output: all fields sorted by index, varint before raw on a tie.
  function automatic void build_expected();
    exp_q.delete();
    for (int i = 0; i < (1 << IDX_W); i++) begin
      foreach (v_pend[j]) if (v_pend[j].idx == IDX_W'(i)) exp_q.push_back(v_pend[j]);
      foreach (r_pend[j]) if (r_pend[j].idx == IDX_W'(i)) exp_q.push_back(r_pend[j]);
    end
  endfunction

  // Plays one message through the DUT and scores every cycle against exp_q.
  task automatic run_msg(input int v_pct, input int r_pct, input int full_pct,
                         input int full_lo, input int full_hi, input int r_delay,
                         output int done_cyc);
    item_t it;
    bit    fin = 1'b0;
    int    k = 0;
    done_cyc = -1;
    while (!fin) begin
      @(negedge clock_clk);
      if (v_pend.size() != 0 && int'($urandom_range(0, 99)) < v_pct)
        v_fifo.push_back(v_pend.pop_front());
      if (k >= r_delay && r_pend.size() != 0 && int'($urandom_range(0, 99)) < r_pct)
        r_fifo.push_back(r_pend.pop_front());
      v_valid = (v_fifo.size() != 0);
      v_data  = v_valid ? v_fifo[0].dat : '0;
      v_index = v_valid ? v_fifo[0].idx : '0;
      r_valid = (r_fifo.size() != 0);
      r_data  = r_valid ? r_fifo[0].dat : '0;
      r_index = r_valid ? r_fifo[0].idx : '0;
      v_done  = (v_pend.size() == 0);
      r_done  = (k >= r_delay) && (r_pend.size() == 0);
      out_full = (k >= full_lo && k < full_hi) || (int'($urandom_range(0, 99)) < full_pct);
      #1;
      checks++;
      if (v_pop && r_pop) begin
        failures++; $display("FAIL dual_pop v_pop=%0b r_pop=%0b want one at most", v_pop, r_pop);
      end
      checks++;
      if (out_full && out_push) begin
        failures++; $display("FAIL push_when_full out_push=%0b want 0", out_push);
      end
      checks++;
      if (msg_bytes !== CNT_W'(cnt_model)) begin
        failures++; $display("FAIL msg_bytes got=%0d want=%0d", msg_bytes, cnt_model);
      end
      checks++;
      if (err_order !== 1'b0) begin
        failures++; $display("FAIL err_order_spurious got=%0b want=0", err_order);
      end
      if (k < r_delay) begin
        checks++;
        if (out_push !== 1'b0) begin
          failures++; $display("FAIL early_push out_push=%0b want 0 before raw arrives", out_push);
        end
      end
      if (out_push === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL extra_push out_data=%0h want no push", out_data);
        end else begin
          it = exp_q.pop_front();
          if (out_data !== it.dat || r_pop !== it.raw) begin
            failures++;
            $display("FAIL out_byte got=%0h raw=%0b want=%0h raw=%0b idx=%0d",
                     out_data, r_pop, it.dat, it.raw, it.idx);
          end
        end
        cnt_model = new_msg ? 1 : ((cnt_model == (1 << CNT_W) - 1) ? cnt_model : cnt_model + 1);
        new_msg = 1'b0;
        if (v_pop && v_fifo.size() != 0) void'(v_fifo.pop_front());
        if (r_pop && r_fifo.size() != 0) void'(r_fifo.pop_front());
      end else begin
        checks++;
        if (out_data !== '0) begin
          failures++; $display("FAIL idle_out_data got=%0h want=0", out_data);
        end
      end
      if (msg_complete === 1'b1) begin
        checks++;
        if (exp_q.size() != 0 || done_ack !== 1'b1) begin
          failures++;
          $display("FAIL complete pending=%0d done_ack=%0b want 0 and 1", exp_q.size(), done_ack);
        end
        done_cyc = k;
        new_msg  = 1'b1;
        v_done   = 1'b0;
        r_done   = 1'b0;
        fin      = 1'b1;
      end else begin
        checks++;
        if (done_ack !== 1'b0) begin
          failures++; $display("FAIL done_ack_stray got=%0b want=0", done_ack);
        end
      end
      k++;
      if (!fin && k >= 3000) begin
        checks++; failures++;
        $display("FAIL msg_timeout cycles=%0d want completion", k);
        v_done = 1'b0; r_done = 1'b0; fin = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    #2 reset_reset = 1'b1;
    #1;
    checks++; if (out_push !== 1'b0)     begin failures++; $display("FAIL rst_out_push got=%0b want=0", out_push); end
    checks++; if (out_data !== '0)       begin failures++; $display("FAIL rst_out_data got=%0h want=0", out_data); end
    checks++; if (v_pop !== 1'b0)        begin failures++; $display("FAIL rst_v_pop got=%0b want=0", v_pop); end
    checks++; if (r_pop !== 1'b0)        begin failures++; $display("FAIL rst_r_pop got=%0b want=0", r_pop); end
    checks++; if (msg_complete !== 1'b0) begin failures++; $display("FAIL rst_msg_complete got=%0b want=0", msg_complete); end
    checks++; if (done_ack !== 1'b0)     begin failures++; $display("FAIL rst_done_ack got=%0b want=0", done_ack); end
    checks++; if (msg_bytes !== '0)      begin failures++; $display("FAIL rst_msg_bytes got=%0d want=0", msg_bytes); end
    checks++; if (err_order !== 1'b0)    begin failures++; $display("FAIL rst_err_order got=%0b want=0", err_order); end
    #19 reset_reset = 1'b0;
    cnt_model = 0;
    new_msg   = 1'b0;
  endtask

  task automatic test_empty_msg();
    int dc;
    build_expected();
    run_msg(100, 100, 0, 0, 0, 0, dc);
    checks++; if (dc != 2)          begin failures++; $display("FAIL empty_latency got=%0d want=2", dc); end
    checks++; if (msg_bytes !== '0) begin failures++; $display("FAIL empty_bytes got=%0d want=0", msg_bytes); end
  endtask

  task automatic test_spec_example();
    int dc;
    push_item(0, 1, 'h96); push_item(0, 1, 'h01); push_item(0, 3, 'h05);
    push_item(1, 2, 'h41); push_item(1, 2, 'h42);
    exp_q.delete();
    exp_q.push_back(item_t'{1'b0, IDX_W'(1), 8'h96});
    exp_q.push_back(item_t'{1'b0, IDX_W'(1), 8'h01});
    exp_q.push_back(item_t'{1'b1, IDX_W'(2), 8'h41});
    exp_q.push_back(item_t'{1'b1, IDX_W'(2), 8'h42});
    exp_q.push_back(item_t'{1'b0, IDX_W'(3), 8'h05});
    run_msg(100, 100, 0, 0, 0, 0, dc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock_clk); #1;
      checks++;
      if (msg_complete !== 1'b0) begin failures++; $display("FAIL example_single_pulse got=%0b want=0", msg_complete); end
    end
    checks++; if (msg_bytes !== CNT_W'(5)) begin failures++; $display("FAIL example_bytes got=%0d want=5", msg_bytes); end
  endtask

  task automatic test_wait_lower_index();
    int dc;
    add_field(0, 4, 1);
    add_field(1, 2, 2);
    build_expected();
    run_msg(100, 100, 0, 0, 0, 6, dc);
    checks++; if (msg_bytes !== CNT_W'(3)) begin failures++; $display("FAIL wait_bytes got=%0d want=3", msg_bytes); end
  endtask

  task automatic test_out_full();
    int dc;
    add_field(1, 3, 4);
    build_expected();
    run_msg(100, 100, 0, 3, 6, 0, dc);
    checks++; if (msg_bytes !== CNT_W'(4)) begin failures++; $display("FAIL full_bytes got=%0d want=4", msg_bytes); end
  endtask

  task automatic test_random_msgs();
    int dc, idx;
    for (int m = 0; m < 10; m++) begin
      for (int s = 0; s < 2; s++) begin
        idx = int'($urandom_range(1, 4));
        for (int f = 0; f < int'($urandom_range(0, 3)); f++) begin
          add_field(s[0], idx, int'($urandom_range(1, 4)));
          idx += int'($urandom_range(1, 3));
        end
      end
      build_expected();
      run_msg(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), 20, 0, 0, 0, dc);
    end
  endtask

  task automatic test_err_order_clr();
    bit seen = 1'b0;
    @(negedge clock_clk);
    v_valid = 1'b1; v_index = IDX_W'(5); v_data = 8'h11; v_done = 1'b0;
    r_valid = 1'b0; r_done = 1'b1; out_full = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      #1;
      if (out_push === 1'b1) seen = 1'b1;
      else @(negedge clock_clk);
    end
    checks++; if (!seen) begin failures++; $display("FAIL err_first_push seen=%0b want=1", seen); end
    @(negedge clock_clk);
    v_index = IDX_W'(2); v_data = 8'h22;
    repeat (3) @(negedge clock_clk);
    #1;
    checks++; if (err_order !== 1'b1) begin failures++; $display("FAIL err_set got=%0b want=1", err_order); end
    repeat (3) @(negedge clock_clk);
    #1;
    checks++; if (err_order !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0b want=1", err_order); end
    @(negedge clock_clk);
    clr = 1'b1;
    #1;
    checks++; if (v_pop !== 1'b0)    begin failures++; $display("FAIL clr_v_pop got=%0b want=0", v_pop); end
    checks++; if (out_push !== 1'b0) begin failures++; $display("FAIL clr_push got=%0b want=0", out_push); end
    @(negedge clock_clk);
    clr = 1'b0; v_valid = 1'b0; v_index = '0; v_data = '0; r_done = 1'b0;
    #1;
    checks++; if (err_order !== 1'b0) begin failures++; $display("FAIL clr_err got=%0b want=0", err_order); end
    checks++; if (msg_bytes !== '0)   begin failures++; $display("FAIL clr_bytes got=%0d want=0", msg_bytes); end
    @(negedge clock_clk);
    v_valid = 1'b1; v_index = IDX_W'(2); v_data = 8'h33;
    #1;
    checks++; if (out_push !== 1'b0) begin failures++; $display("FAIL clr_idle got=%0b want=0", out_push); end
    @(negedge clock_clk);
    v_valid = 1'b0; v_index = '0; v_data = '0; clr = 1'b1;
    @(negedge clock_clk);
    clr = 1'b0;
    cnt_model = 0;
    new_msg   = 1'b0;
  endtask

  task automatic test_reset_mid_field();
    int npush = 0;
    int dc;
    @(negedge clock_clk);
    v_valid = 1'b1; v_index = IDX_W'(1); v_data = 8'h5A; v_done = 1'b0;
    r_valid = 1'b0; r_done = 1'b1; out_full = 1'b0;
    for (int i = 0; i < 12 && npush < 2; i++) begin
      #1;
      if (out_push === 1'b1) npush++;
      if (npush < 2) @(negedge clock_clk);
    end
    checks++; if (npush != 2)              begin failures++; $display("FAIL mid_pushes got=%0d want=2", npush); end
    checks++; if (msg_bytes !== CNT_W'(1)) begin failures++; $display("FAIL mid_bytes got=%0d want=1", msg_bytes); end
    #2 reset_reset = 1'b1;
    #1;
    checks++; if (out_push !== 1'b0) begin failures++; $display("FAIL mid_rst_push got=%0b want=0", out_push); end
    checks++; if (v_pop !== 1'b0)    begin failures++; $display("FAIL mid_rst_pop got=%0b want=0", v_pop); end
    checks++; if (out_data !== '0)   begin failures++; $display("FAIL mid_rst_data got=%0h want=0", out_data); end
    checks++; if (msg_bytes !== '0)  begin failures++; $display("FAIL mid_rst_bytes got=%0d want=0", msg_bytes); end
    @(negedge clock_clk);
    v_valid = 1'b0; v_index = '0; v_data = '0; r_done = 1'b0;
    #3 reset_reset = 1'b0;
    cnt_model = 0;
    new_msg   = 1'b0;
    add_field(0, 2, 3);
    add_field(1, 1, 2);
    build_expected();
    run_msg(100, 100, 0, 0, 0, 0, dc);
    checks++; if (msg_bytes !== CNT_W'(5)) begin failures++; $display("FAIL post_rst_bytes got=%0d want=5", msg_bytes); end
  endtask

  initial begin
    test_reset();
    test_empty_msg();
    test_spec_example();
    test_wait_lower_index();
    test_out_full();
    test_random_msgs();
    test_err_order_clr();
    test_reset_mid_field();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
